// File: rtl/time_display.sv
// time_display
//   Converts the binary second/minute/hour counters of the timer clock into BCD
//   and drives six seven-segment displays:
//   HEX5:4 = hour, HEX3:2 = minute, HEX1:0 = second.
//   While a field is selected for setting, that field blinks.
//
//   The BCD conversion is a sequential shift-add-3 (double dabble). All three
//   fields are converted in parallel over 6 cycles.
//
// Parameters
//   SEG_ACTIVE_LOW  1: a segment is lit by driving 0 (DE2 HEX); 0: lit by driving 1
//   BLINK_TICKS     number of blink_tick pulses per blink-phase toggle (>= 1)
//
// Ports
//   clk, rst_n           clock; asynchronous active-low reset
//   second, minute       binary values, 0..59 nominal (6 bits)
//   hour                 binary value, 0..23 nominal (5 bits)
//   mode                 00 run, 01 set sec, 10 set min, 11 set hour
//   blink_tick           1-cycle strobe that advances the blink divider
//   hex0..hex5           registered segment outputs {g,f,e,d,c,b,a}
//   busy                 high while the conversion FSM is not IDLE
//   upd_done             1-cycle pulse when new digits have been latched
//   pm                   PM indicator; present only with DISP_12H_EN
//
// Build option
//   DISP_12H_EN: 12-hour display (hour 0 shown as 12, 13..23 as 1..11) and adds pm.
module time_display #(
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int BLINK_TICKS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] second,
  input  logic [5:0] minute,
  input  logic [4:0] hour,
  input  logic [1:0] mode,
  input  logic       blink_tick,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic [6:0] hex4,
  output logic [6:0] hex5,
  output logic       busy,
  output logic       upd_done
`ifdef DISP_12H_EN
  ,
  output logic       pm
`endif
);

  typedef enum logic [1:0] {IDLE, CONV, LATCH} state_t;

  localparam int CNT_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  state_t            state, state_nxt;
  logic [16:0]       inputs_now;
  logic [16:0]       snap;
  // {tens, ones, binary} working registers for each field
  logic [13:0]       sec_dd, min_dd, hr_dd;
  logic [2:0]        step;
  logic [5:0][3:0]   dig;      // [0]=sec ones ... [5]=hour tens
  logic [5:0][6:0]   hex_r;
  logic [CNT_W-1:0]  blink_cnt;
  logic              phase;
  logic [2:0]        blank_pair;
  logic              pm_cap;
`ifndef DISP_12H_EN
  logic              pm;
`endif

  assign inputs_now = {hour, minute, second};

  // One double-dabble step: correct nibbles >= 5, then shift in the next bit.
  function automatic logic [13:0] dd_step(input logic [13:0] v);
    logic [13:0] a;
    a = v;
    if (a[9:6] >= 4'd5)   a[9:6]   = a[9:6] + 4'd3;
    if (a[13:10] >= 4'd5) a[13:10] = a[13:10] + 4'd3;
    return {a[12:0], 1'b0};
  endfunction

  function automatic logic [5:0] hour_disp(input logic [4:0] h);
`ifdef DISP_12H_EN
    if (h == 5'd0)        return 6'd12;
    else if (h <= 5'd12)  return {1'b0, h};
    else                  return {1'b0, h - 5'd12};
`else
    return {1'b0, h};
`endif
  endfunction

  function automatic logic [6:0] seg(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h00;
    endcase
    return (SEG_ACTIVE_LOW != 0) ? ~p : p;
  endfunction

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (inputs_now != snap) state_nxt = CONV;
      CONV:    if (step == 3'd5)       state_nxt = LATCH;
      LATCH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state != IDLE);
  end

  // Capture, conversion and digit latch. The snapshot holds the raw inputs so a
  // change during CONV/LATCH is detected once the FSM is back in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap     <= '0;
      sec_dd   <= '0;
      min_dd   <= '0;
      hr_dd    <= '0;
      step     <= '0;
      dig      <= '0;
      upd_done <= 1'b0;
      pm_cap   <= 1'b0;
      pm       <= 1'b0;
    end else begin
      upd_done <= 1'b0;
      case (state)
        IDLE: begin
          if (inputs_now != snap) begin
            snap   <= inputs_now;
            sec_dd <= {8'd0, second};
            min_dd <= {8'd0, minute};
            hr_dd  <= {8'd0, hour_disp(hour)};
            pm_cap <= (hour >= 5'd12);
            step   <= '0;
          end
        end
        CONV: begin
          sec_dd <= dd_step(sec_dd);
          min_dd <= dd_step(min_dd);
          hr_dd  <= dd_step(hr_dd);
          step   <= step + 3'd1;
        end
        LATCH: begin
          dig      <= {hr_dd[13:10], hr_dd[9:6], min_dd[13:10], min_dd[9:6],
                       sec_dd[13:10], sec_dd[9:6]};
          pm       <= pm_cap;
          upd_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Blink divider: phase toggles on every BLINK_TICKS-th blink_tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_tick) begin
      if (blink_cnt == CNT_W'(BLINK_TICKS - 1)) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    blank_pair = '0;
    if (phase) begin
      case (mode)
        2'b01:   blank_pair[0] = 1'b1;
        2'b10:   blank_pair[1] = 1'b1;
        2'b11:   blank_pair[2] = 1'b1;
        default: blank_pair = '0;
      endcase
    end
  end

  // Segment registers re-encode every cycle so blink/mode changes show next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) hex_r[i] <= seg(4'd0);
    end else begin
      for (int i = 0; i < 6; i++)
        hex_r[i] <= blank_pair[i/2] ? SEG_OFF : seg(dig[i]);
    end
  end

  assign hex0 = hex_r[0];
  assign hex1 = hex_r[1];
  assign hex2 = hex_r[2];
  assign hex3 = hex_r[3];
  assign hex4 = hex_r[4];
  assign hex5 = hex_r[5];

endmodule

// File: tb/tb_time_display.sv
module tb_time_display;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] second, minute;
  logic [4:0] hour;
  logic [1:0] mode;
  logic       blink_tick;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
  logic       busy, upd_done;
  logic       pm_obs;
  logic [42:0] obs;

  always #5 clk = ~clk;

  time_display dut (
    .clk(clk), .rst_n(rst_n),
    .second(second), .minute(minute), .hour(hour),
    .mode(mode), .blink_tick(blink_tick),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
    .busy(busy), .upd_done(upd_done)
`ifdef DISP_12H_EN
    , .pm(pm_obs)
`endif
  );

`ifndef DISP_12H_EN
  assign pm_obs = 1'b0;
`endif

  assign obs = {pm_obs, hex5, hex4, hex3, hex2, hex1, hex0};

  localparam logic [42:0] RST_EXP = {1'b0, {6{7'h40}}};

  int errs = 0;
  int checks = 0;
  int upd_cnt = 0;
  logic [42:0] sb[$];
  logic [42:0] cur_exp;

  always @(negedge clk) if (upd_done === 1'b1) upd_cnt++;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [6:0] seg_al(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [42:0] model(input int s, input int m, input int h);
    int hh;
    logic p;
    hh = h;
    p = 1'b0;
`ifdef DISP_12H_EN
    p = (h >= 12);
    if (h == 0) hh = 12;
    else if (h > 12) hh = h - 12;
`endif
    return {p, seg_al(hh / 10), seg_al(hh % 10), seg_al(m / 10), seg_al(m % 10),
            seg_al(s / 10), seg_al(s % 10)};
  endfunction

  // Drive new inputs (caller is at a negedge) and queue the expected display.
  task automatic drive(input int s, input int m, input int h);
    if (s != int'(second) || m != int'(minute) || h != int'(hour))
      sb.push_back(model(s, m, h));
    second = 6'(s);
    minute = 6'(m);
    hour   = 5'(h);
  endtask

  // Wait (bounded) for upd_done, then compare the display one edge later.
  task automatic expect_update(input string tag);
    bit ok;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (upd_done === 1'b1) begin ok = 1; break; end
    end
    if (!ok) begin
      check({tag, "_timeout"}, 0, 1);
      return;
    end
    @(negedge clk);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
    end else begin
      cur_exp = sb.pop_front();
      check(tag, obs, cur_exp);
    end
  endtask

  task automatic pulse_tick();
    blink_tick = 1'b1;
    @(negedge clk);
    blink_tick = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [42:0] e;
    rst_n = 1'b0; second = '0; minute = '0; hour = '0; mode = 2'b00; blink_tick = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cur_exp = RST_EXP;

    // Reset state, no input change
    repeat (12) @(negedge clk);
    check("rst_hex", obs, RST_EXP);
    check("rst_busy", busy, 0);
    check("rst_no_upd", upd_cnt, 0);

    // Latency: seconds 0 -> 59
    base = upd_cnt;
    drive(59, 0, 0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check($sformatf("lat_busy_E%0d", i), busy, 1);
    end
    @(negedge clk);
    check("lat_busy_E7", busy, 0);
    check("lat_upd_E7", upd_done, 1);
    @(negedge clk);
    check("lat_upd_E8", upd_done, 0);
    cur_exp = sb.pop_front();
    check("lat_hex_E8", obs, cur_exp);
    check("lat_one_pulse", upd_cnt - base, 1);

    // Hour 23, minute 45
    drive(0, 45, 23);
    expect_update("h23_m45");

    // Out-of-range values shown as decimal
    @(negedge clk);
    drive(63, 59, 31);
    expect_update("out_of_range");

    // 12-hour edge cases (also plain decimal in 24-hour builds)
    @(negedge clk);
    drive(0, 0, 13);
    expect_update("hour13");
    @(negedge clk);
    drive(0, 0, 0);
    expect_update("hour0");
    @(negedge clk);
    drive(0, 0, 12);
    expect_update("hour12");

    // Change mid-conversion: 5 then 6 sampled at E2
    @(negedge clk);
    drive(5, 0, 0);
    base = upd_cnt;
    repeat (2) @(negedge clk);
    drive(6, 0, 0);
    expect_update("mid_first");
    expect_update("mid_second");
    repeat (20) @(negedge clk);
    check("mid_pulses", upd_cnt - base, 2);

    // Glitch that returns before IDLE samples it: one update only
    drive(8, 0, 0);
    base = upd_cnt;
    repeat (2) @(negedge clk);
    second = 6'd9;
    @(negedge clk);
    second = 6'd8;
    expect_update("glitch_val");
    repeat (20) @(negedge clk);
    check("glitch_pulses", upd_cnt - base, 1);

    // Random values
    for (int i = 0; i < 6; i++) begin
      int s, m, h;
      s = $urandom_range(0, 63);
      m = $urandom_range(0, 63);
      h = $urandom_range(0, 31);
      @(negedge clk);
      if (s == int'(second) && m == int'(minute) && h == int'(hour)) s = (s + 1) % 64;
      drive(s, m, h);
      expect_update($sformatf("rand%0d", i));
    end

    // Blink: mode 10
    @(negedge clk);
    mode = 2'b10;
    @(negedge clk);
    @(negedge clk);
    check("blink_min_ph0", obs, cur_exp);
    pulse_tick();
    @(negedge clk);
    e = cur_exp; e[27:14] = 14'h3FFF;
    check("blink_min_ph1", obs, e);
    pulse_tick();
    @(negedge clk);
    check("blink_min_restore", obs, cur_exp);

    // Blink: mode 11, then mode 00 with phase 1, then mode 01
    mode = 2'b11;
    pulse_tick();
    @(negedge clk);
    e = cur_exp; e[41:28] = 14'h3FFF;
    check("blink_hour_ph1", obs, e);
    mode = 2'b00;
    @(negedge clk);
    @(negedge clk);
    check("blink_run_noblank", obs, cur_exp);
    mode = 2'b01;
    @(negedge clk);
    @(negedge clk);
    e = cur_exp; e[13:0] = 14'h3FFF;
    check("blink_sec_ph1", obs, e);
    pulse_tick();
    mode = 2'b00;
    @(negedge clk);
    @(negedge clk);
    check("blink_sec_restore", obs, cur_exp);

    // Reset mid-conversion
    drive(1, 2, 3);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    second = '0; minute = '0; hour = '0;
    #1;
    check("rstmid_busy", busy, 0);
    check("rstmid_hex", obs, RST_EXP);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    base = upd_cnt;
    repeat (15) @(negedge clk);
    check("rstmid_hold_hex", obs, RST_EXP);
    check("rstmid_no_upd", upd_cnt - base, 0);
    check("rstmid_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
